// File: rtl/change_dispenser_if.sv
// Coin dispenser bus: job request and status towards the host, eject/ack
// handshake towards the three coin hoppers.
interface change_dispenser_if;
  logic       start_i;
  logic [7:0] amount_i;
  logic [2:0] stock_i;
  logic [2:0] ack_i;
  logic [2:0] eject_o;
  logic       busy_o;
  logic       done_o;
  logic       err_o;
  logic [7:0] remain_o;
  logic [7:0] coins_o;

  // Host/hopper side: drives requests, stock and acks, observes status.
  modport master (
    output start_i, amount_i, stock_i, ack_i,
    input  eject_o, busy_o, done_o, err_o, remain_o, coins_o
  );

  // Dispenser side.
  modport slave (
    input  start_i, amount_i, stock_i, ack_i,
    output eject_o, busy_o, done_o, err_o, remain_o, coins_o
  );
endinterface

// File: rtl/change_dispenser.sv
// Greedy change dispenser: pays an amount in jiao using 1 yuan, 5 jiao and
// 1 jiao hoppers, one coin at a time with a 4-phase eject/ack handshake.
// A hopper that fails to ack within ACK_TIMEOUT cycles is marked jammed for
// the rest of the job and the next smaller coin is tried instead.
module change_dispenser #(
  parameter logic [15:0] ACK_TIMEOUT = 16'd50000
) (
  input logic          clk_i,
  input logic          n_reset_i,
  change_dispenser_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SELECT   = 3'd1,
    EJECT    = 3'd2,
    WAIT_REL = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  remain_q, remain_d;
  logic [7:0]  coins_q, coins_d;
  logic        err_q, err_d;
  logic [2:0]  jam_q, jam_d;
  logic [2:0]  sel_q, sel_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  avail;
  logic [2:0]  eject;
  logic        done;

  // Coin value in jiao for a one-hot hopper selection.
  function automatic logic [7:0] coin_value(input logic [2:0] sel);
    case (sel)
      3'b100:  coin_value = 8'd10;
      3'b010:  coin_value = 8'd5;
      3'b001:  coin_value = 8'd1;
      default: coin_value = 8'd0;
    endcase
  endfunction

  // Coin counter increment that sticks at the top of its range.
  function automatic logic [7:0] sat_inc(input logic [7:0] value);
    sat_inc = (value == 8'hFF) ? value : value + 8'd1;
  endfunction

  // State and job registers; reset clears everything, including mid-job.
  always_ff @(posedge clk_i) begin
    if (!n_reset_i) begin
      state_q  <= IDLE;
      remain_q <= 8'd0;
      coins_q  <= 8'd0;
      err_q    <= 1'b0;
      jam_q    <= 3'b000;
      sel_q    <= 3'b000;
      cnt_q    <= 16'd0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      coins_q  <= coins_d;
      err_q    <= err_d;
      jam_q    <= jam_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state, job bookkeeping and Moore outputs.
  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    coins_d  = coins_q;
    err_d    = err_q;
    jam_d    = jam_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    eject    = 3'b000;
    done     = 1'b0;
    avail    = bus.stock_i & ~jam_q;

    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          remain_d = bus.amount_i;
          coins_d  = 8'd0;
          err_d    = 1'b0;
          jam_d    = 3'b000;
          state_d  = SELECT;
        end
      end

      SELECT: begin
        // err is settled on the way into DONE so it is valid with the pulse.
        if (remain_q == 8'd0) begin
          err_d   = 1'b0;
          state_d = DONE;
        end else if (remain_q >= 8'd10 && avail[2]) begin
          sel_d   = 3'b100;
          cnt_d   = 16'd0;
          state_d = EJECT;
        end else if (remain_q >= 8'd5 && avail[1]) begin
          sel_d   = 3'b010;
          cnt_d   = 16'd0;
          state_d = EJECT;
        end else if (avail[0]) begin
          sel_d   = 3'b001;
          cnt_d   = 16'd0;
          state_d = EJECT;
        end else begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end

      EJECT: begin
        eject = sel_q;
        // An ack on the last allowed cycle still counts as a coin.
        if ((bus.ack_i & sel_q) != 3'b000) begin
          remain_d = remain_q - coin_value(sel_q);
          coins_d  = sat_inc(coins_q);
          state_d  = WAIT_REL;
        end else if (cnt_q >= ACK_TIMEOUT - 16'd1) begin
          jam_d   = jam_q | sel_q;
          state_d = SELECT;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      WAIT_REL: begin
        if ((bus.ack_i & sel_q) == 3'b000) begin
          state_d = SELECT;
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.eject_o  = eject;
  assign bus.done_o   = done;
  assign bus.busy_o   = (state_q != IDLE);
  assign bus.err_o    = err_q;
  assign bus.remain_o = remain_q;
  assign bus.coins_o  = coins_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: hopper responders, an eject monitor and a
// greedy-payout reference model, with directed and randomized jobs.
module tb_change_dispenser;

  localparam logic [15:0] TO = 16'd8;

  logic clk = 1'b0;
  logic n_reset;

  change_dispenser_if bus ();

  change_dispenser #(.ACK_TIMEOUT(TO)) dut (
    .clk_i     (clk),
    .n_reset_i (n_reset),
    .bus       (bus.slave)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Hopper behaviour: live hoppers ack after a delay, dead ones never do.
  logic [2:0] dead = 3'b000;
  int         fixed_dly = 0;
  int         hcnt[3];
  int         dly[3];
  int         rel[3];

  initial begin
    bus.ack_i = 3'b000;
    for (int i = 0; i < 3; i++) begin
      hcnt[i] = 0; dly[i] = 1; rel[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (bus.eject_o[i]) begin
          if (hcnt[i] == 0) dly[i] = (fixed_dly > 0) ? fixed_dly : $urandom_range(1, 5);
          hcnt[i]++;
          if (!dead[i] && hcnt[i] >= dly[i] && !bus.ack_i[i]) begin
            bus.ack_i[i] = 1'b1;
            rel[i] = $urandom_range(0, 2);
          end
        end else begin
          hcnt[i] = 0;
          if (bus.ack_i[i]) begin
            if (rel[i] == 0) bus.ack_i[i] = 1'b0;
            else rel[i]--;
          end
        end
      end
    end
  end

  // Eject monitor: records each eject pulse (value, length in cycles).
  int         pv[$];
  int         pl[$];
  logic [2:0] prev_ej = 3'b000;
  bit         multi = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (bus.eject_o !== 3'b000) begin
        if (bus.eject_o !== prev_ej) begin
          pv.push_back(int'(bus.eject_o));
          pl.push_back(1);
        end else begin
          pl[pl.size()-1] = pl[pl.size()-1] + 1;
        end
        if ($countones(bus.eject_o) != 1) multi = 1'b1;
      end
      prev_ej = bus.eject_o;
    end
  end

  // Reference: greedy payout; a dead hopper costs one attempt, then is skipped.
  int m_seq[$];
  int m_coins;
  int m_rem;
  int m_err;

  function automatic void model(input int amt, input logic [2:0] stk, input logic [2:0] dd);
    int         val[3] = '{1, 5, 10};
    logic [2:0] jam = 3'b000;
    m_seq.delete();
    m_rem   = amt;
    m_coins = 0;
    while (m_rem > 0) begin
      int pick = -1;
      for (int i = 2; i >= 0; i--)
        if (pick < 0 && stk[i] && !jam[i] && m_rem >= val[i]) pick = i;
      if (pick < 0) break;
      m_seq.push_back(1 << pick);
      if (dd[pick]) jam[pick] = 1'b1;
      else begin
        m_rem -= val[pick];
        if (m_coins < 255) m_coins++;
      end
    end
    m_err = (m_rem != 0) ? 1 : 0;
  endfunction

  int lat;

  task automatic run_job(input string tag, input int amt, input logic [2:0] stk,
                         input logic [2:0] dd, input bit noisy, output int latency);
    int n;
    model(amt, stk, dd);
    dead        = dd;
    bus.stock_i = stk;
    @(negedge clk);
    pv.delete(); pl.delete(); multi = 1'b0;
    bus.amount_i = amt[7:0];
    bus.start_i  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({tag, ".busy_start"}, bus.busy_o, 1);
    if (noisy) bus.amount_i = 8'($urandom_range(0, 255));
    else bus.start_i = 1'b0;
    latency = 1;
    while (!bus.done_o && latency < 5000) begin
      @(negedge clk);
      latency++;
    end
    bus.start_i = 1'b0;
    check({tag, ".done_seen"}, bus.done_o, 1);
    check({tag, ".busy_done"}, bus.busy_o, 1);
    check({tag, ".err"}, bus.err_o, m_err);
    check({tag, ".remain"}, bus.remain_o, m_rem);
    check({tag, ".coins"}, bus.coins_o, m_coins);
    check({tag, ".npulses"}, pv.size(), m_seq.size());
    n = (pv.size() < m_seq.size()) ? pv.size() : m_seq.size();
    for (int k = 0; k < n; k++) begin
      check({tag, ".eject_val"}, pv[k], m_seq[k]);
      if ((m_seq[k] & int'(dd)) != 0) check({tag, ".timeout_len"}, pl[k], int'(TO));
      else if (fixed_dly > 0) check({tag, ".ack_len"}, pl[k], fixed_dly);
    end
    check({tag, ".onehot"}, multi, 0);
    @(negedge clk);
    check({tag, ".done_pulse"}, bus.done_o, 0);
    check({tag, ".busy_after"}, bus.busy_o, 0);
    check({tag, ".err_hold"}, bus.err_o, m_err);
    check({tag, ".remain_hold"}, bus.remain_o, m_rem);
    check({tag, ".coins_hold"}, bus.coins_o, m_coins);
  endtask

  initial begin
    int  waitc;
    bit  found;
    n_reset      = 1'b0;
    bus.start_i  = 1'b0;
    bus.amount_i = 8'd0;
    bus.stock_i  = 3'b000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.eject", bus.eject_o, 0);
    check("rst.busy", bus.busy_o, 0);
    check("rst.done", bus.done_o, 0);
    check("rst.err", bus.err_o, 0);
    check("rst.remain", bus.remain_o, 0);
    check("rst.coins", bus.coins_o, 0);
    n_reset = 1'b1;

    // Mixed coins, fixed 3-cycle ack.
    fixed_dly = 3;
    run_job("amt27", 27, 3'b111, 3'b000, 1'b0, lat);
    check("amt27.coins_c", bus.coins_o, 5);
    // No 1 yuan hopper.
    run_job("amt14", 14, 3'b011, 3'b000, 1'b1, lat);
    check("amt14.coins_c", bus.coins_o, 6);
    // Only 1 yuan stocked, amount too small: immediate failure.
    run_job("amt7", 7, 3'b100, 3'b000, 1'b0, lat);
    check("amt7.lat", lat, 2);
    check("amt7.err_c", bus.err_o, 1);
    check("amt7.remain_c", bus.remain_o, 7);
    // Zero amount.
    run_job("amt0", 0, 3'b111, 3'b000, 1'b0, lat);
    check("amt0.lat", lat, 2);
    check("amt0.err_c", bus.err_o, 0);
    // 1 yuan hopper jammed: timeout, then two 5 jiao coins.
    run_job("jam10", 10, 3'b111, 3'b100, 1'b0, lat);
    check("jam10.coins_c", bus.coins_o, 2);
    check("jam10.err_c", bus.err_o, 0);
    // Largest amount paid entirely in 1 jiao coins.
    fixed_dly = 0;
    run_job("amt255", 255, 3'b001, 3'b000, 1'b0, lat);
    check("amt255.coins_c", bus.coins_o, 255);

    // Reset in the middle of a 5 jiao eject, with a start pulse alongside.
    dead = 3'b000;
    bus.stock_i = 3'b011;
    @(negedge clk);
    bus.amount_i = 8'd14;
    bus.start_i  = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    found = 1'b0;
    waitc = 0;
    while (!found && waitc < 200) begin
      @(negedge clk);
      waitc++;
      if (bus.eject_o == 3'b010) found = 1'b1;
    end
    check("midrst.found", found, 1);
    bus.start_i  = 1'b1;
    bus.amount_i = 8'd99;
    n_reset      = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_reset     = 1'b1;
    bus.start_i = 1'b0;
    check("midrst.eject", bus.eject_o, 0);
    check("midrst.busy", bus.busy_o, 0);
    check("midrst.done", bus.done_o, 0);
    check("midrst.err", bus.err_o, 0);
    check("midrst.remain", bus.remain_o, 0);
    check("midrst.coins", bus.coins_o, 0);
    repeat (5) @(negedge clk);

    // Randomized jobs, some with dead hoppers and noisy start/amount.
    for (int j = 0; j < 40; j++) begin
      int         amt;
      logic [2:0] stk;
      logic [2:0] dd;
      bit         noisy;
      amt   = $urandom_range(0, 60);
      stk   = 3'($urandom_range(0, 7));
      dd    = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      noisy = 1'($urandom_range(0, 1));
      run_job("rnd", amt, stk, dd, noisy, lat);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
